// File: rtl/range_scan_ctrl.sv
// Scans the Collatz range result RAM for the largest count (lowest index on ties), sharing the
// single read port with display reads that always take priority. `define RANGE_SCAN_MIN_EN adds min tracking.
module range_scan_ctrl #(
    parameter int RAM_WORDS     = 256,
    parameter int RAM_ADDR_BITS = 8,
    parameter int COUNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     go,
    input  logic                     range_done,
    output logic [RAM_ADDR_BITS-1:0] rd_addr,
    input  logic [COUNT_W-1:0]       rd_data,
    input  logic                     disp_req,
    input  logic [RAM_ADDR_BITS-1:0] disp_addr,
    output logic [COUNT_W-1:0]       disp_data,
    output logic                     disp_valid,
    output logic                     busy,
    output logic                     done,
    output logic [COUNT_W-1:0]       max_count,
    output logic [RAM_ADDR_BITS-1:0] max_idx
`ifdef RANGE_SCAN_MIN_EN
    ,
    output logic [COUNT_W-1:0]       min_count,
    output logic [RAM_ADDR_BITS-1:0] min_idx
`endif
);

    localparam int PTR_W = RAM_ADDR_BITS + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RAM_WORDS - 1);

    typedef enum logic [2:0] {IDLE, WAIT_RANGE, SCAN, DRAIN, DONE} state_t;

    state_t                     state_q;
    logic [PTR_W-1:0]           ptr_q;
    logic                       tag_vld_q;
    logic                       tag_disp_q;
    logic [RAM_ADDR_BITS-1:0]   tag_addr_q;
    logic [COUNT_W-1:0]         disp_data_q;
    logic                       disp_valid_q;
    logic                       busy_q;
    logic                       done_q;
    logic [COUNT_W-1:0]         max_count_q;
    logic [RAM_ADDR_BITS-1:0]   max_idx_q;

    logic scan_issue;
    logic abort;
    logic scan_ret;
    logic scan_hit;
    logic clear_res;

    always_comb begin
        scan_issue = (state_q == SCAN) && range_done && !disp_req;
        abort      = ((state_q == SCAN) || (state_q == DRAIN)) && !range_done;
        clear_res  = (((state_q == IDLE) || (state_q == DONE)) && go) || abort;
        scan_ret   = tag_vld_q && !tag_disp_q;
        scan_hit   = scan_ret && !abort && (rd_data > max_count_q);
        // Display owns the port whenever it asks; otherwise the pointer drives it.
        rd_addr    = disp_req ? disp_addr : ptr_q[RAM_ADDR_BITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            tag_vld_q    <= 1'b0;
            tag_disp_q   <= 1'b0;
            tag_addr_q   <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            max_count_q  <= '0;
            max_idx_q    <= '0;
        end else begin
            // Read issue stage: owner tag and address travel with each read.
            tag_vld_q    <= disp_req || scan_issue;
            tag_disp_q   <= disp_req;
            tag_addr_q   <= rd_addr;

            // Return stage: route returning data to display or comparator.
            disp_valid_q <= tag_vld_q && tag_disp_q;
            if (tag_vld_q && tag_disp_q) begin
                disp_data_q <= rd_data;
            end

            if (clear_res) begin
                max_count_q <= '0;
                max_idx_q   <= '0;
                ptr_q       <= '0;
            end else begin
                if (scan_hit) begin
                    max_count_q <= rd_data;
                    max_idx_q   <= tag_addr_q;
                end
                if (scan_issue) begin
                    ptr_q <= ptr_q + PTR_W'(1);
                end
            end

            unique case (state_q)
                IDLE, DONE: begin
                    if (go) begin
                        state_q <= WAIT_RANGE;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                WAIT_RANGE: begin
                    if (range_done) begin
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (abort) begin
                        state_q <= WAIT_RANGE;
                    end else if (scan_issue && (ptr_q == LAST_PTR)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state_q <= WAIT_RANGE;
                    end else if (!scan_ret) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef RANGE_SCAN_MIN_EN
    logic [COUNT_W-1:0]       min_count_q;
    logic [RAM_ADDR_BITS-1:0] min_idx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            min_count_q <= '1;
            min_idx_q   <= '0;
        end else if (clear_res) begin
            min_count_q <= '1;
            min_idx_q   <= '0;
        end else if (scan_ret && (rd_data < min_count_q)) begin
            min_count_q <= rd_data;
            min_idx_q   <= tag_addr_q;
        end
    end

    assign min_count = min_count_q;
    assign min_idx   = min_idx_q;
`endif

    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign max_count  = max_count_q;
    assign max_idx    = max_idx_q;

endmodule

// File: doc/range_scan_ctrl.md
Name: range_scan_ctrl

Overview:
- Sequences a full read-out of the Collatz range result RAM (RAM_WORDS entries of COUNT_W-bit iteration counts) after the range engine reports done.
- Reports the maximum count and the lowest index holding it.
- Arbitrates the single RAM read port between its own scan and display-side reads; display reads always win.
- Sits between the range engine's read port and the top-level display/button logic.

Parameters:
- RAM_WORDS, 256, number of result words scanned.
- RAM_ADDR_BITS, 8, read address width; RAM_WORDS <= 2**RAM_ADDR_BITS.
- COUNT_W, 16, width of each stored iteration count.

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- reset  input  1  synchronous, active-high reset.
- go  input  1  one-cycle pulse; requests a scan.
- range_done  input  1  high while range RAM contents are valid.
- rd_addr  output  RAM_ADDR_BITS  read address to range RAM.
- rd_data  input  COUNT_W  RAM data; valid the cycle after rd_addr is presented (1-cycle synchronous read).
- disp_req  input  1  display read request, sampled each cycle.
- disp_addr  input  RAM_ADDR_BITS  display read address.
- disp_data  output  COUNT_W  display read result.
- disp_valid  output  1  one-cycle pulse; disp_data is valid.
- busy  output  1  high in WAIT_RANGE, SCAN and DRAIN.
- done  output  1  high in DONE; result outputs are valid.
- max_count  output  COUNT_W  largest count found.
- max_idx  output  RAM_ADDR_BITS  lowest index holding max_count.

Behaviour:
- Reset: state IDLE; rd_addr, disp_data, max_count and max_idx are 0; disp_valid, busy and done are 0; scan pointer is 0.
- IDLE: go -> WAIT_RANGE. Pointer is cleared to 0, max_count to 0 and max_idx to 0.
- WAIT_RANGE: stays until range_done = 1, then -> SCAN in the next cycle.
- SCAN, port ownership:
  - Each cycle, if disp_req = 1, the display owns the port: rd_addr = disp_addr and the pointer holds.
  - Otherwise the scanner owns it: rd_addr = pointer and the pointer increments.
  - When the pointer issues address RAM_WORDS-1 -> DRAIN.
- DRAIN: waits for the last scan datum to return, then -> DONE. Display requests are still served.
- Read tagging:
  - A one-bit owner tag and the issued address are registered with every read.
  - The next cycle, a display tag gives disp_data <= rd_data and disp_valid = 1.
  - A scan tag gives compare rd_data > max_count (strict). If true, max_count <= rd_data and max_idx <= tagged address.
  - Strict compare means ties keep the lowest index.
- DONE: done = 1 and results are held. go -> WAIT_RANGE, starting a fresh scan with results cleared. Display requests are served in every state.
- IDLE/DONE with disp_req: rd_addr = disp_addr; disp_valid and disp_data follow one cycle later.
- Display read latency: always exactly 1 cycle after disp_req is sampled. Back-to-back disp_req every cycle is legal; the scan stalls for as long as it persists.
- go while busy: ignored.
- range_done falls during SCAN/DRAIN: abort to WAIT_RANGE. The pointer and results are cleared, and in-flight scan data is discarded. The scan restarts when range_done rises.
- Mid-operation reset: immediate return to the reset state; any in-flight read result is dropped and disp_valid is not asserted.
- Widths:
  - Pointer is RAM_ADDR_BITS+1 bits to detect the end without wrap; rd_addr takes the low bits.
  - max_count never wraps.
  - An all-zero RAM yields max_count = 0 and max_idx = 0.

Optional Feature:
- Macro: RANGE_SCAN_MIN_EN.
- Defined:
  - Adds outputs min_count (COUNT_W) and min_idx (RAM_ADDR_BITS).
  - At scan start, min_count is cleared to all ones and min_idx to 0.
  - Update on strict rd_data < min_count; ties keep the lowest index.
  - Valid when done = 1. Reset values are all ones and 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- RAM[i] = i for i = 0..255, go with range_done = 1 -> busy for 258 cycles after WAIT_RANGE exits, then done = 1, max_count = 255, max_idx = 255.
- RAM all 5 except RAM[17] = 111 and RAM[200] = 111 -> max_count = 111, max_idx = 17 (tie keeps the lowest).
- Scan with disp_req = 1 at disp_addr = 42 (RAM[42] = 0x1F) for 3 consecutive cycles mid-scan -> disp_valid on 3 cycles each with 0x1F; scan completes 3 cycles later; max result unchanged.
- go with range_done = 0 for 10 cycles, then 1 -> stays in WAIT_RANGE with busy = 1, rd_addr driven only by display; SCAN starts 1 cycle after range_done rises.
- range_done dropped at pointer = 100, re-raised 5 cycles later -> results cleared; full rescan yields the same result as an uninterrupted scan.
- Reset asserted at pointer = 60 with a display read in flight -> next cycle all outputs are 0, disp_valid = 0; go after reset gives a correct full scan.
